cdma_lite_cfg_master: RTL

AXI4-Lite master that programs an AXI CDMA in simple mode and, optionally, polls it to completion. A `dma_en` pulse starts a three-register write sequence: source address, destination address, byte length. The block then polls the CDMA status register until Idle or error and reports one done/error result. It sits between the core's DMA request logic and the CDMA AXI-Lite slave port, and generalises the earlier fire-and-forget controller with:
- independent AW/W handshakes;
- B and R response checking;
- completion polling with a timeout;
- parametrised offsets and widths.

---
 rtl/cdma_lite_cfg_master.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cdma_lite_cfg_master.sv
// AXI4-Lite master that programs an AXI CDMA (SA, DA, BTT) in simple mode and
// optionally polls its status register until Idle, error or timeout.
module cdma_lite_cfg_master #(
    parameter int unsigned        ADDR_W     = 10,
    parameter int unsigned        DATA_W     = 32,
    parameter logic [ADDR_W-1:0]  SA_OFFSET  = 10'h18,
    parameter logic [ADDR_W-1:0]  DA_OFFSET  = 10'h20,
    parameter logic [ADDR_W-1:0]  BTT_OFFSET = 10'h28,
    parameter logic [ADDR_W-1:0]  SR_OFFSET  = 10'h04,
    parameter bit                 POLL_EN    = 1'b1,
    parameter int unsigned        POLL_LIMIT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dma_en,
    input  logic [DATA_W-1:0]   read_addr,
    input  logic [DATA_W-1:0]   write_addr,
    input  logic [DATA_W-1:0]   byte_length,
    output logic                busy,
    output logic                dma_done,
    output logic                dma_err,
    output logic [1:0]          err_code,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WAIT_B,
        S_RD_A,
        S_RD_D,
        S_DONE
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [1:0]          r_idx,      w_idx_nxt;
    logic [DATA_W-1:0]   r_sa,       w_sa_nxt;
    logic [DATA_W-1:0]   r_da,       w_da_nxt;
    logic [DATA_W-1:0]   r_btt,      w_btt_nxt;
    logic [CNT_W-1:0]    r_poll_cnt, w_poll_nxt;
    logic                r_awvalid,  w_awvalid_nxt;
    logic [ADDR_W-1:0]   r_awaddr,   w_awaddr_nxt;
    logic                r_wvalid,   w_wvalid_nxt;
    logic [DATA_W-1:0]   r_wdata,    w_wdata_nxt;
    logic [STRB_W-1:0]   r_wstrb,    w_wstrb_nxt;
    logic                r_bready,   w_bready_nxt;
    logic                r_arvalid,  w_arvalid_nxt;
    logic [ADDR_W-1:0]   r_araddr,   w_araddr_nxt;
    logic                r_rready,   w_rready_nxt;
    logic                r_busy,     w_busy_nxt;
    logic                r_dma_done, w_done_nxt;
    logic                r_dma_err,  w_err_nxt;
    logic [1:0]          r_err_code, w_err_code_nxt;
    logic                w_issue_wr;
    logic [CNT_W-1:0]    w_poll_inc;
    logic                w_unused_rdata;

    // Status bits outside Idle and the error field carry no meaning here.
    assign w_unused_rdata = ^{rdata[DATA_W-1:7], rdata[3:2], rdata[0]};

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_sa       <= '0;
            r_da       <= '0;
            r_btt      <= '0;
            r_poll_cnt <= '0;
            r_awvalid  <= 1'b0;
            r_awaddr   <= '0;
            r_wvalid   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bready   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_rready   <= 1'b0;
            r_busy     <= 1'b0;
            r_dma_done <= 1'b0;
            r_dma_err  <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_sa       <= w_sa_nxt;
            r_da       <= w_da_nxt;
            r_btt      <= w_btt_nxt;
            r_poll_cnt <= w_poll_nxt;
            r_awvalid  <= w_awvalid_nxt;
            r_awaddr   <= w_awaddr_nxt;
            r_wvalid   <= w_wvalid_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wstrb    <= w_wstrb_nxt;
            r_bready   <= w_bready_nxt;
            r_arvalid  <= w_arvalid_nxt;
            r_araddr   <= w_araddr_nxt;
            r_rready   <= w_rready_nxt;
            r_busy     <= w_busy_nxt;
            r_dma_done <= w_done_nxt;
            r_dma_err  <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_sa_nxt       = r_sa;
        w_da_nxt       = r_da;
        w_btt_nxt      = r_btt;
        w_poll_nxt     = r_poll_cnt;
        w_awvalid_nxt  = 1'b0;
        w_awaddr_nxt   = '0;
        w_wvalid_nxt   = 1'b0;
        w_wdata_nxt    = '0;
        w_wstrb_nxt    = '0;
        w_bready_nxt   = 1'b0;
        w_arvalid_nxt  = 1'b0;
        w_araddr_nxt   = '0;
        w_rready_nxt   = 1'b0;
        w_err_code_nxt = r_err_code;
        w_issue_wr     = 1'b0;
        w_poll_inc     = r_poll_cnt + CNT_W'(1);

        case (r_state)
            S_IDLE: begin
                if (dma_en) begin
                    w_sa_nxt       = read_addr;
                    w_da_nxt       = write_addr;
                    w_btt_nxt      = byte_length;
                    w_idx_nxt      = 2'd0;
                    w_err_code_nxt = 2'd0;
                    w_issue_wr     = 1'b1;
                    w_state_nxt    = S_WR;
                end
            end
            S_WR: begin
                // AW and W retire independently; leave once both are accepted.
                w_awvalid_nxt = r_awvalid & ~awready;
                w_awaddr_nxt  = w_awvalid_nxt ? r_awaddr : '0;
                w_wvalid_nxt  = r_wvalid & ~wready;
                w_wdata_nxt   = w_wvalid_nxt ? r_wdata : '0;
                w_wstrb_nxt   = w_wvalid_nxt ? '1 : '0;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                w_bready_nxt = 1'b1;
                if (bvalid) begin
                    w_bready_nxt = 1'b0;
                    if (bresp != 2'b00) begin
                        w_err_code_nxt = 2'd1;
                        w_state_nxt    = S_DONE;
                    end else if (r_idx != 2'd2) begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_issue_wr  = 1'b1;
                        w_state_nxt = S_WR;
                    end else if (POLL_EN) begin
                        w_poll_nxt    = '0;
                        w_arvalid_nxt = 1'b1;
                        w_araddr_nxt  = SR_OFFSET;
                        w_state_nxt   = S_RD_A;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RD_A: begin
                w_arvalid_nxt = ~arready;
                w_araddr_nxt  = arready ? '0 : SR_OFFSET;
                if (arready) begin
                    w_rready_nxt = 1'b1;
                    w_state_nxt  = S_RD_D;
                end
            end
            S_RD_D: begin
                w_rready_nxt = 1'b1;
                if (rvalid) begin
                    w_rready_nxt = 1'b0;
                    if (rresp != 2'b00 || rdata[6:4] != 3'd0) begin
                        w_err_code_nxt = 2'd2;
                        w_state_nxt    = S_DONE;
                    end else if (rdata[1]) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_poll_nxt = w_poll_inc;
                        if (POLL_LIMIT != 0 && w_poll_inc == CNT_W'(POLL_LIMIT)) begin
                            w_err_code_nxt = 2'd3;
                            w_state_nxt    = S_DONE;
                        end else begin
                            w_arvalid_nxt = 1'b1;
                            w_araddr_nxt  = SR_OFFSET;
                            w_state_nxt   = S_RD_A;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Launch the write selected by the (next) register index.
        if (w_issue_wr) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_wstrb_nxt   = '1;
            case (w_idx_nxt)
                2'd0: begin
                    w_awaddr_nxt = SA_OFFSET;
                    w_wdata_nxt  = w_sa_nxt;
                end
                2'd1: begin
                    w_awaddr_nxt = DA_OFFSET;
                    w_wdata_nxt  = w_da_nxt;
                end
                default: begin
                    w_awaddr_nxt = BTT_OFFSET;
                    w_wdata_nxt  = w_btt_nxt;
                end
            endcase
        end

        w_done_nxt = (w_state_nxt == S_DONE);
        w_err_nxt  = w_done_nxt && (w_err_code_nxt != 2'd0);
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign busy     = r_busy;
    assign dma_done = r_dma_done;
    assign dma_err  = r_dma_err;
    assign err_code = r_err_code;
    assign awaddr   = r_awaddr;
    assign awvalid  = r_awvalid;
    assign wdata    = r_wdata;
    assign wstrb    = r_wstrb;
    assign wvalid   = r_wvalid;
    assign bready   = r_bready;
    assign araddr   = r_araddr;
    assign arvalid  = r_arvalid;
    assign rready   = r_rready;

endmodule
